// File: rtl/ble_cmd_seq.sv
// ble_cmd_seq: FIFO-driven command sequencer feeding UART_tx with programmable post-byte gaps, one-shot or looped.
module ble_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 8,
  parameter int DLY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_cmd,
  input  logic [DLY_W-1:0] wr_dly,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_mode,
  input  logic             clr_ovfl,
  input  logic             tx_done,
  output logic             trmt,
  output logic [CMD_W-1:0] tx_data,
  output logic             busy,
  output logic             empty,
  output logic             full,
  output logic             ovfl,
  output logic             seq_done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, GAP} state_t;
  state_t state_q, state_d;
  logic [CMD_W-1:0] cmd_q [DEPTH];
  logic [DLY_W-1:0] dly_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] gap_q, gap_d, push_dly;
  logic [CMD_W-1:0] tx_data_q, tx_data_d, push_cmd;
  logic trmt_q, trmt_d, ovfl_q, ovfl_d, seq_done_q, seq_done_d, tx_done_q;
  logic pop, recirc, wr_ok, push, rise, next_go;
  assign busy = state_q != IDLE;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign rise = tx_done & ~tx_done_q;
  assign trmt = trmt_q;
  assign tx_data = tx_data_q;
  assign ovfl = ovfl_q;
  assign seq_done = seq_done_q;
  always_comb begin
    pop = state_q == LOAD && !abort;
    recirc = pop && loop_mode;
    // the recirculated entry owns the write port, so an external write that cycle is dropped
    wr_ok = wr_en && !recirc && (!full || pop);
    push = recirc || wr_ok;
    push_cmd = recirc ? cmd_q[rd_q] : wr_cmd;
    push_dly = recirc ? dly_q[rd_q] : wr_dly;
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovfl_d = (ovfl_q && !clr_ovfl) || (wr_en && !wr_ok);
    tx_data_d = pop ? cmd_q[rd_q] : tx_data_q;
    gap_d = pop ? dly_q[rd_q] : state_q == GAP ? gap_q - DLY_W'(1) : gap_q;
    next_go = (state_q == WAIT_TX && rise && gap_q == '0) || (state_q == GAP && gap_q == DLY_W'(1));
    state_d = abort ? IDLE :
      state_q == IDLE ? (start && !empty ? LOAD : IDLE) :
      state_q == LOAD ? SEND :
      state_q == SEND ? WAIT_TX :
      next_go ? (empty ? IDLE : LOAD) :
      (state_q == WAIT_TX && rise) ? GAP : state_q;
    trmt_d = pop;
    seq_done_d = !abort && next_go && empty;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_q[wr_q] <= push_cmd;
      dly_q[wr_q] <= push_dly;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      tx_data_q <= '0;
      trmt_q <= 1'b0;
      ovfl_q <= 1'b0;
      seq_done_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      tx_data_q <= tx_data_d;
      trmt_q <= trmt_d;
      ovfl_q <= ovfl_d;
      seq_done_q <= seq_done_d;
      tx_done_q <= tx_done;
    end
  end
endmodule

// File: tb/tb_ble_cmd_seq.sv
// tb_ble_cmd_seq: directed-plus-random checks of ble_cmd_seq against a queue-based timing model.
module tb_ble_cmd_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, abort = 1'b0, loop_mode = 1'b0, clr_ovfl = 1'b0, tx_done = 1'b0;
  logic [7:0] wr_cmd = '0;
  logic [23:0] wr_dly = '0;
  logic trmt, busy, empty, full, ovfl, seq_done;
  logic [7:0] tx_data;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] qc [$];
  logic [23:0] qd [$];
  logic ovfl_m = 1'b0;
  ble_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_dly(wr_dly),
    .start(start), .abort(abort), .loop_mode(loop_mode), .clr_ovfl(clr_ovfl),
    .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data), .busy(busy), .empty(empty),
    .full(full), .ovfl(ovfl), .seq_done(seq_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] c, input logic [23:0] d);
    wr_en = 1'b1;
    wr_cmd = c;
    wr_dly = d;
    tick();
    wr_en = 1'b0;
    if (qc.size() < 8) begin
      qc.push_back(c);
      qd.push_back(d);
    end else ovfl_m = 1'b1;
  endtask
  task automatic wait_trmt(input int lim);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!trmt && n < lim);
  endtask
  // called in the cycle where the first trmt of a one-shot run is expected
  task automatic drain(input string tag);
    logic [23:0] d;
    int r;
    chk({tag, "_trmt"}, {31'b0, trmt}, 1);
    while (qc.size() > 0) begin
      chk({tag, "_data"}, {24'b0, tx_data}, {24'b0, qc[0]});
      void'(qc.pop_front());
      d = qd.pop_front();
      tx_done = 1'b0;
      tick();
      chk({tag, "_pulse"}, {31'b0, trmt}, 0);
      repeat ($urandom_range(0, 5)) tick();
      tx_done = 1'b1;
      r = cyc;
      if (qc.size() == 0) begin
        while (cyc < r + int'(d) + 1) tick();
        chk({tag, "_seq_done"}, {31'b0, seq_done}, 1);
        chk({tag, "_idle"}, {30'b0, busy, empty}, 32'd1);
        tick();
        chk({tag, "_seq_once"}, {31'b0, seq_done}, 0);
      end else begin
        wait_trmt(int'(d) + 20);
        chk({tag, "_gap"}, cyc - r, d + 2);
      end
    end
    tx_done = 1'b0;
  endtask
  initial begin
    logic [7:0] c;
    logic [23:0] d;
    int r;
    logic seen;
    tick();
    tick();
    chk("rst_outs", {trmt, busy, empty, full, ovfl, seq_done}, 32'b001000);
    chk("rst_data", {24'b0, tx_data}, 0);
    rst_n = 1'b1;
    tick();
    wr(8'h47, 24'd1000);
    wr(8'h53, 24'd0);
    chk("a_not_empty", {31'b0, empty}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_load", {30'b0, busy, trmt}, 32'b10);
    tick();
    drain("a");
    for (int i = 0; i < 9; i++) begin
      wr(8'($urandom), 24'($urandom_range(0, 20)));
      if (i == 6) chk("ov_not_full7", {31'b0, full}, 0);
      if (i == 7) chk("ov_full8", {30'b0, full, ovfl}, 32'b10);
    end
    chk("ov_dropped", {30'b0, full, ovfl}, {30'b0, 1'b1, ovfl_m});
    clr_ovfl = 1'b1;
    tick();
    clr_ovfl = 1'b0;
    ovfl_m = 1'b0;
    chk("ov_clear", {30'b0, full, ovfl}, 32'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 8'($urandom);
    d = 24'($urandom_range(0, 20));
    wr_en = 1'b1;
    wr_cmd = c;
    wr_dly = d;
    qc.push_back(c);
    qd.push_back(d);
    tick();
    wr_en = 1'b0;
    chk("ov_load_write", {30'b0, full, ovfl}, 32'b10);
    drain("ov");
    repeat (3) wr(8'($urandom), 24'($urandom_range(3, 12)));
    loop_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1;
    wr_cmd = 8'hEE;
    wr_dly = 24'd5;
    tick();
    wr_en = 1'b0;
    ovfl_m = 1'b1;
    chk("lp_ovfl", {31'b0, ovfl}, {31'b0, ovfl_m});
    chk("lp_trmt", {31'b0, trmt}, 1);
    for (int k = 0; k < 8; k++) begin
      chk("lp_data", {24'b0, tx_data}, {24'b0, qc[0]});
      c = qc.pop_front();
      qc.push_back(c);
      d = qd.pop_front();
      qd.push_back(d);
      tx_done = 1'b0;
      tick();
      chk("lp_not_empty", {31'b0, empty}, 0);
      repeat ($urandom_range(0, 4)) tick();
      tx_done = 1'b1;
      r = cyc;
      if (k < 7) begin
        wait_trmt(int'(d) + 20);
        chk("lp_gap", cyc - r, d + 2);
      end else begin
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("lp_abort_idle", {31'b0, busy}, 0);
        seen = 1'b0;
        repeat (int'(d) + 10) begin
          tick();
          seen = seen | trmt;
        end
        chk("lp_abort_quiet", {31'b0, seen}, 0);
      end
    end
    loop_mode = 1'b0;
    chk("lp_count", {29'b0, empty, full, ovfl}, 32'b001);
    clr_ovfl = 1'b1;
    tick();
    clr_ovfl = 1'b0;
    ovfl_m = 1'b0;
    chk("lp_clr", {31'b0, ovfl}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    drain("lp_rest");
    wr(8'h5A, 24'd7);
    wr(8'hA5, 24'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rs_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_outs", {trmt, busy, empty, full, ovfl, seq_done}, 32'b001000);
    chk("rs_async_data", {24'b0, tx_data}, 0);
    qc = {};
    qd = {};
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_start_empty", {30'b0, busy, empty}, 32'b01);
    tick();
    chk("rs_no_trmt", {31'b0, trmt}, 0);
    wr(8'h33, 24'd2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen = seen | busy | trmt;
      tick();
    end
    chk("sa_abort_wins", {31'b0, seen}, 0);
    chk("sa_kept", {31'b0, empty}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ble_cmd_seq.md
# ble_cmd_seq

Parametrised, synthesizable BLE command sequencer that replaces hand-timed command sends in the Segway system benches and bring-up top. A host (bench or debug logic) loads a FIFO of {command byte, post-send gap} entries. On `start`, the block drives `UART_tx` (`trmt`/`tx_data`, completion via `tx_done`), waits the programmed gap after each byte, and either drains the FIFO (one-shot) or recirculates it indefinitely (loop mode).

## Interface
- `DEPTH`, default 8: FIFO entries; power of 2, minimum 2.
- `CMD_W`, default 8: command width; must match `UART_tx` data width.
- `DLY_W`, default 24: gap counter width, in clk cycles.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: push {`wr_cmd`, `wr_dly`}.
- `wr_cmd` in CMD_W: command byte, e.g. 8'h47 'G' or 8'h53 'S'.
- `wr_dly` in DLY_W: idle cycles inserted after this byte's `tx_done`.
- `start` in 1: begin sequencing; ignored unless in IDLE.
- `abort` in 1: synchronous return to IDLE.
- `loop_mode` in 1: 1 = recirculate each popped entry to the tail. Sampled only in LOAD.
- `clr_ovfl` in 1: clears `ovfl`.
- `tx_done` in 1: from `UART_tx`; level signal, only its rising edge is used.
- `trmt` out 1: one-cycle transmit strobe.
- `tx_data` out CMD_W: current command, held from LOAD until the next LOAD.
- `busy` out 1: state is not IDLE.
- `empty` out 1: entry count is 0.
- `full` out 1: entry count equals DEPTH.
- `ovfl` out 1: sticky, set when a write is dropped.
- `seq_done` out 1: one-cycle pulse when a one-shot run finishes.

## Operation
- Storage: circular FIFO with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- Write acceptance: a write is dropped and `ovfl` set when either:
  - `full` is high with no pop in the same cycle; or
  - a recirculation occurs in the same cycle.
- Recirculation has priority over an external write.
- Write while not full in a one-shot LOAD cycle: the pop and the push both occur; count is unchanged.
- States:
  - IDLE: `start` and not `empty` -> LOAD. `start` with `empty` is ignored.
  - LOAD: latch head into `tx_data` and the gap counter, then pop. In loop mode, push the same entry back to the tail. -> SEND.
  - SEND: `trmt`=1 for this cycle only. -> WAIT_TX.
  - WAIT_TX: rising edge of `tx_done` (registered previous-value detect) -> GAP if gap>0; otherwise -> NEXT decision.
  - GAP: decrement each cycle; at 1 -> NEXT decision.
  - NEXT decision: not `empty` -> LOAD; `empty` -> IDLE with a `seq_done` pulse.
  - Loop mode never empties, so it runs until `abort`.
- `abort`: any state -> IDLE on the next edge. `trmt` is forced low in that cycle. FIFO contents are kept, except an entry already popped in one-shot mode is lost.
- An abort in WAIT_TX does not stop a byte already in `UART_tx`.
- `abort` and `start` in the same cycle: `abort` wins.
- `clr_ovfl` and a dropped write in the same cycle: `ovfl` remains 1.

## Timing
- Reset values: state IDLE, pointers and count 0, `trmt` 0, `tx_data` 0, `busy` 0, `empty` 1, `full` 0, `ovfl` 0, `seq_done` 0, edge-detect flop 0.
- `start` sampled at edge 0: LOAD in cycle 1, `trmt` high in cycle 2, `busy` high from cycle 1.
- `tx_done` rise detected in cycle t with gap N: the next `trmt` is in cycle t+N+2.
- Minimum gap between bytes (N=0) is therefore 2 cycles after detection.
- `seq_done` is asserted in cycle t+N+1. `busy` falls in that same cycle.
- `empty`/`full` update the cycle after a push or pop; no combinational path from `wr_en`.
- All outputs are registered except `busy`, `empty` and `full`, which are decoded from registered state.

## Test plan
- Load {47,1000}, {53,0}; pulse `start`:
  - `trmt` in cycle 2 with `tx_data`=47;
  - second `trmt` exactly 1002 cycles after the first `tx_done` rise, with `tx_data`=53;
  - `seq_done` pulses once, `empty`=1.
- Write 9 entries with DEPTH=8 while idle -> `full`=1 after the 8th write, the 9th is dropped, `ovfl`=1. `clr_ovfl` -> `ovfl`=0 with contents intact.
- Loop mode with 3 entries A, B, C -> byte order A B C A B C A…, count stays 3, `empty` never asserts. `abort` mid-GAP -> IDLE next cycle and no further `trmt`.
- External `wr_en` in the LOAD cycle during loop mode -> write dropped, `ovfl`=1, count unchanged.
- Assert `rst_n`=0 asynchronously in WAIT_TX -> all outputs at reset values immediately. After release, `start` alone is ignored because the FIFO is empty.
- `start` with an empty FIFO, then `start` and `abort` in the same cycle with a non-empty FIFO -> neither produces `trmt`, and `busy` stays 0.
